vx_afu_ctrl: RTL and testbench
==============================

Name: vx_afu_ctrl

Overview:
AXI4-Lite control slave for the Vortex XRT AFU. It exposes an HLS-style register map: AP_CTRL, interrupt control, device capabilities, and a DCR write port. The host uses it to launch and reset the accelerator, poll or take an interrupt on completion, and program device configuration registers (DCRs). It sits between the platform's s_axi_ctrl port and the AFU run-control state machine.

Parameters:
S_AXI_ADDR_WIDTH, 8, AXI-Lite address width.
S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
DCR_ADDR_WIDTH, 12, width of dcr_wr_addr.
DCR_DATA_WIDTH, 32, width of dcr_wr_data.
DEV_CAPS, 64'h0, constant returned by the DEV_CAPS registers.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axi_awvalid/awready  in/out  1/1  write-address handshake
s_axi_awaddr  in  S_AXI_ADDR_WIDTH  write address
s_axi_wvalid/wready  in/out  1/1  write-data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid/bready  out/in  1/1  write-response handshake
s_axi_bresp  out  2  always 2'b00
s_axi_arvalid/arready  in/out  1/1  read-address handshake
s_axi_araddr  in  S_AXI_ADDR_WIDTH  read address
s_axi_rvalid/rready  out/in  1/1  read-data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
ap_start  out  1  kernel start
ap_reset  out  1  one-cycle kernel reset pulse
ap_done  in  1  kernel done (level)
ap_ready  in  1  kernel accepted start
ap_idle  in  1  kernel idle
interrupt  out  1  level interrupt to host
dcr_wr_valid  out  1  one-cycle DCR write strobe
dcr_wr_addr  out  DCR_ADDR_WIDTH  DCR address
dcr_wr_data  out  DCR_DATA_WIDTH  DCR data

Behaviour:
- Register offsets are decoded on addr[S_AXI_ADDR_WIDTH-1:2]. Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 AP_CTRL:
    - bit0 start: RW; self-clears.
    - bit1 done: read-clear.
    - bit2 idle: RO, reflects the ap_idle input.
    - bit3 ready: RO, reflects the ap_ready input.
    - bit4 reset: W1, pulses ap_reset.
    - bit7 auto_restart: RW.
  - 0x04 GIE: bit0.
  - 0x08 IER: bit0 done, bit1 ready.
  - 0x0C ISR: bits 1:0; write-1-toggles.
  - 0x10 DEV_CAPS[31:0], RO.
  - 0x14 DEV_CAPS[63:32], RO.
  - 0x18 DCR_ADDR: RW, low DCR_ADDR_WIDTH bits.
  - 0x1C DCR_DATA: W; the write triggers a DCR write.
- Write channel FSM WRIDLE -> WRDATA -> WRRESP -> WRIDLE:
  - awready=1 only in WRIDLE; the address is latched on aw fire.
  - wready=1 only in WRDATA; register update occurs on w fire.
  - bvalid=1 only in WRRESP; the FSM returns to WRIDLE on bready.
- Read channel FSM RDIDLE -> RDDATA -> RDIDLE:
  - arready=1 only in RDIDLE.
  - rdata is registered on ar fire; rvalid=1 in RDDATA and holds until rready.
- The read and write FSMs are independent and may fire in the same cycle.
- wstrb applies per byte lane to RW registers. AP_CTRL, GIE, IER and ISR use lane 0 only.
- ap_start register:
  - Set by a write with bit0=1.
  - Cleared when ap_ready=1 in a cycle where it is set, unless auto_restart=1.
  - With ap_ready tied high, start is a one-cycle pulse.
  - Also cleared by an ap_reset pulse.
- done bit: set in any cycle ap_done=1; cleared by an AP_CTRL read; a set and a read-clear in the same cycle resolve to set.
- ap_reset: a write with bit4=1 produces exactly one cycle of ap_reset=1, the cycle after w fire.
- dcr_wr_valid: one cycle after w fire to 0x1C, with dcr_wr_addr=DCR_ADDR and dcr_wr_data=the written word with strobes applied.
- Reset values:
  - All registers 0; ap_start=0, ap_reset=0, dcr_wr_valid=0, interrupt=0.
  - bvalid=rvalid=0; awready=arready=1.
  - ap_done edge-detect register resets to 1, so a done level present at reset release does not raise ISR.
- Reset asserted mid-transaction aborts it; no response is issued.

Optional Feature:
Macro VX_AFU_CTRL_IRQ_EN.
- Defined:
  - ISR bit0 is set on a rising edge of ap_done when IER bit0 is set.
  - ISR bit1 is set on ap_ready while start is set, when IER bit1 is set.
  - A write-1 to ISR toggles the bit; a hardware set wins over a toggle in the same cycle.
  - interrupt = GIE & |ISR, registered, so one cycle of latency.
- Undefined: GIE/IER/ISR read 0, writes are ignored, interrupt is tied 0.

Test Plan:
- Write 0x00=0x1 with ap_ready=1 -> bresp=0, ap_start high for exactly 1 cycle, AP_CTRL read bit0=0.
- Write 0x18=0x005, then 0x1C=0xDEADBEEF with wstrb=0xF -> single dcr_wr_valid pulse with addr=0x005, data=0xDEADBEEF.
- Hold ap_done=1, ap_idle=1 and read 0x00 -> rdata=0x6. Drop ap_done, read twice -> 0x6 then 0x4.
- Write 0x00=0x10 -> one ap_reset pulse. Read 0x10/0x14 with DEV_CAPS=64'h1122334455667788 -> 0x55667788, 0x11223344.
- IRQ_EN: GIE=1, IER=1, raise ap_done 0->1 -> ISR=0x1, interrupt=1. Write ISR=0x1 -> interrupt=0.
- Hold bready=0/rready=0 while issuing a second aw/ar -> awready/arready stay 0 until the response handshakes. Assert reset mid-burst -> FSMs return to idle, outputs at reset values.

Source files
------------

// File: rtl/vx_afu_ctrl.sv
// vx_afu_ctrl: AXI4-Lite control slave for the Vortex XRT AFU.
// HLS-style register map (AP_CTRL, GIE/IER/ISR, DEV_CAPS, DCR write port).
// Optional interrupt logic is built when VX_AFU_CTRL_IRQ_EN is defined;
// without it GIE/IER/ISR read 0, ignore writes and interrupt stays 0.
//
// Handshake semantics: every AXI channel transfers on a cycle where both
// valid and ready are high at the rising clock edge. Once a response valid
// (bvalid/rvalid) is raised it holds, together with its payload, until the
// matching ready is seen. Ready outputs are pure decodes of the state
// registers and never depend combinationally on the master's valid.
module vx_afu_ctrl #(
    parameter int          S_AXI_ADDR_WIDTH = 8,
    parameter int          S_AXI_DATA_WIDTH = 32,
    parameter int          DCR_ADDR_WIDTH   = 12,
    parameter int          DCR_DATA_WIDTH   = 32,
    parameter logic [63:0] DEV_CAPS         = 64'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          ap_start,
    output logic                          ap_reset,
    input  logic                          ap_done,
    input  logic                          ap_ready,
    input  logic                          ap_idle,
    output logic                          interrupt,
    output logic                          dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0]     dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0]     dcr_wr_data,
    output logic [2:0]                    dbg_fsm_state  // {rd_state, wr_state[1:0]}
);

    localparam int AW = S_AXI_ADDR_WIDTH;
    localparam int DW = S_AXI_DATA_WIDTH;

    // Word indexes (address bits [AW-1:2]) of the register map
    localparam logic [AW-3:0] IDX_AP_CTRL  = (AW-2)'(0);
    localparam logic [AW-3:0] IDX_GIE      = (AW-2)'(1);
    localparam logic [AW-3:0] IDX_IER      = (AW-2)'(2);
    localparam logic [AW-3:0] IDX_ISR      = (AW-2)'(3);
    localparam logic [AW-3:0] IDX_CAPS_LO  = (AW-2)'(4);
    localparam logic [AW-3:0] IDX_CAPS_HI  = (AW-2)'(5);
    localparam logic [AW-3:0] IDX_DCR_ADDR = (AW-2)'(6);
    localparam logic [AW-3:0] IDX_DCR_DATA = (AW-2)'(7);

    typedef enum logic [1:0] {WRIDLE = 2'd0, WRDATA = 2'd1, WRRESP = 2'd2} wr_state_t;
    typedef enum logic       {RDIDLE = 1'b0, RDDATA = 1'b1} rd_state_t;

    wr_state_t               wr_state;
    rd_state_t               rd_state;
    logic [AW-3:0]           waddr_idx;
    logic [AW-3:0]           raddr_idx;
    logic                    w_fire;
    logic                    ar_fire;
    logic [DW-1:0]           wmask;
    logic [DW-1:0]           wdata_masked;
    logic [DW-1:0]           rd_mux;
    logic                    auto_restart;
    logic                    done_r;
    logic [DCR_ADDR_WIDTH-1:0] dcr_addr_r;
    logic                    wr_ctrl;
    logic [DW-1:0]           gie_rd;
    logic [DW-1:0]           ier_rd;
    logic [DW-1:0]           isr_rd;
    logic                    unused_addr_bits;

    assign s_axi_awready = (wr_state == WRIDLE);
    assign s_axi_wready  = (wr_state == WRDATA);
    assign s_axi_bvalid  = (wr_state == WRRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = (rd_state == RDIDLE);
    assign s_axi_rvalid  = (rd_state == RDDATA);
    assign s_axi_rresp   = 2'b00;
    assign dbg_fsm_state = {rd_state, wr_state};

    assign w_fire    = s_axi_wvalid & s_axi_wready;
    assign ar_fire   = s_axi_arvalid & s_axi_arready;
    assign raddr_idx = s_axi_araddr[AW-1:2];
    // AP_CTRL/GIE/IER/ISR only honour byte lane 0
    assign wr_ctrl   = w_fire && (waddr_idx == IDX_AP_CTRL) && s_axi_wstrb[0];
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Expand byte strobes into a bit mask
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DW/8; i++) begin
            wmask[i*8 +: 8] = {8{s_axi_wstrb[i]}};
        end
    end
    assign wdata_masked = s_axi_wdata & wmask;

    // Write channel FSM: address, then data, then response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state  <= WRIDLE;
            waddr_idx <= '0;
        end else begin
            case (wr_state)
                WRIDLE: if (s_axi_awvalid) begin
                    waddr_idx <= s_axi_awaddr[AW-1:2];
                    wr_state  <= WRDATA;
                end
                WRDATA: if (s_axi_wvalid) wr_state <= WRRESP;
                WRRESP: if (s_axi_bready) wr_state <= WRIDLE;
                default: wr_state <= WRIDLE;
            endcase
        end
    end

    // Read data selection; unmapped and write-only offsets read as 0
    always_comb begin
        rd_mux = '0;
        case (raddr_idx)
            IDX_AP_CTRL:  rd_mux = DW'({auto_restart, 3'b000, ap_ready, ap_idle, done_r, ap_start});
            IDX_GIE:      rd_mux = gie_rd;
            IDX_IER:      rd_mux = ier_rd;
            IDX_ISR:      rd_mux = isr_rd;
            IDX_CAPS_LO:  rd_mux = DW'(DEV_CAPS[31:0]);
            IDX_CAPS_HI:  rd_mux = DW'(DEV_CAPS[63:32]);
            IDX_DCR_ADDR: rd_mux = DW'(dcr_addr_r);
            default:      rd_mux = '0;
        endcase
    end

    // Read channel FSM: capture read data on address accept, hold until rready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state    <= RDIDLE;
            s_axi_rdata <= '0;
        end else begin
            case (rd_state)
                RDIDLE: if (s_axi_arvalid) begin
                    s_axi_rdata <= rd_mux;
                    rd_state    <= RDDATA;
                end
                RDDATA: if (s_axi_rready) rd_state <= RDIDLE;
                default: rd_state <= RDIDLE;
            endcase
        end
    end

    // Kernel run control: start, auto-restart, reset pulse and sticky done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ap_start     <= 1'b0;
            auto_restart <= 1'b0;
            ap_reset     <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            ap_reset <= wr_ctrl && s_axi_wdata[4];
            if (wr_ctrl) auto_restart <= s_axi_wdata[7];
            if (ap_reset)                          ap_start <= 1'b0;
            else if (wr_ctrl && s_axi_wdata[0])    ap_start <= 1'b1;
            else if (ap_ready && !auto_restart)    ap_start <= 1'b0;
            // A done level in the same cycle as the clearing read keeps done set
            if (ap_done)                                  done_r <= 1'b1;
            else if (ar_fire && raddr_idx == IDX_AP_CTRL) done_r <= 1'b0;
        end
    end

    // DCR address register and one-cycle DCR write strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcr_addr_r   <= '0;
            dcr_wr_valid <= 1'b0;
            dcr_wr_addr  <= '0;
            dcr_wr_data  <= '0;
        end else begin
            dcr_wr_valid <= 1'b0;
            if (w_fire && waddr_idx == IDX_DCR_ADDR)
                dcr_addr_r <= DCR_ADDR_WIDTH'((DW'(dcr_addr_r) & ~wmask) | wdata_masked);
            if (w_fire && waddr_idx == IDX_DCR_DATA) begin
                dcr_wr_valid <= 1'b1;
                dcr_wr_addr  <= dcr_addr_r;
                dcr_wr_data  <= DCR_DATA_WIDTH'(wdata_masked);
            end
        end
    end

`ifdef VX_AFU_CTRL_IRQ_EN
    logic       gie;
    logic [1:0] ier;
    logic [1:0] isr;
    logic [1:0] isr_set;
    logic [1:0] isr_tgl;
    logic       done_prev;

    assign isr_set = {ier[1] & ap_ready & ap_start, ier[0] & ap_done & ~done_prev};
    assign isr_tgl = (w_fire && waddr_idx == IDX_ISR && s_axi_wstrb[0]) ? s_axi_wdata[1:0] : 2'b00;
    assign gie_rd  = DW'(gie);
    assign ier_rd  = DW'(ier);
    assign isr_rd  = DW'(isr);

    // Interrupt enables, status (hardware set beats host toggle) and output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie       <= 1'b0;
            ier       <= 2'b00;
            isr       <= 2'b00;
            done_prev <= 1'b1;  // a done level present at reset release is not an edge
            interrupt <= 1'b0;
        end else begin
            done_prev <= ap_done;
            if (w_fire && waddr_idx == IDX_GIE && s_axi_wstrb[0]) gie <= s_axi_wdata[0];
            if (w_fire && waddr_idx == IDX_IER && s_axi_wstrb[0]) ier <= s_axi_wdata[1:0];
            isr       <= (isr ^ isr_tgl) | isr_set;
            interrupt <= gie & (|isr);
        end
    end
`else
    assign gie_rd    = '0;
    assign ier_rd    = '0;
    assign isr_rd    = '0;
    assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_vx_afu_ctrl.sv
// Directed bench for vx_afu_ctrl: stimulus tasks push expected read data,
// write responses and DCR strobes into queues; negedge monitors pop and compare.
module tb_vx_afu_ctrl;

  localparam int BOUND = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_awvalid, s_axi_awready;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        ap_start, ap_reset, ap_done, ap_ready, ap_idle, interrupt;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic [2:0]  dbg_fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int rst_cnt   = 0;
  int dcr_cnt   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  addr_q[$];
  logic [1:0]  bresp_q[$];
  logic [43:0] dcr_q[$];

  vx_afu_ctrl #(
    .S_AXI_ADDR_WIDTH(8),
    .S_AXI_DATA_WIDTH(32),
    .DCR_ADDR_WIDTH(12),
    .DCR_DATA_WIDTH(32),
    .DEV_CAPS(64'h1122334455667788)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .ap_start(ap_start), .ap_reset(ap_reset), .ap_done(ap_done), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .interrupt(interrupt),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .dbg_fsm_state(dbg_fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles, got no handshake expected handshake", name, BOUND);
  endtask

  // monitors: read data, write response, DCR strobes, pulse counters
  always @(negedge clk) begin
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        logic [7:0]  a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rdata@%02h", a), s_axi_rdata, e);
        check("rresp", {30'd0, s_axi_rresp}, 32'd0);
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      if (bresp_q.size() == 0) begin
        check("unexpected_bvalid", 32'd1, 32'd0);
      end else begin
        logic [1:0] eb;
        eb = bresp_q.pop_front();
        check("bresp", {30'd0, s_axi_bresp}, {30'd0, eb});
      end
    end
    if (dcr_wr_valid) begin
      dcr_cnt++;
      if (dcr_q.size() == 0) begin
        check("unexpected_dcr", 32'd1, 32'd0);
      end else begin
        logic [43:0] ed;
        ed = dcr_q.pop_front();
        check("dcr_addr", {20'd0, dcr_wr_addr}, {20'd0, ed[43:32]});
        check("dcr_data", dcr_wr_data, ed[31:0]);
      end
    end
    if (ap_start) start_cnt++;
    if (ap_reset) rst_cnt++;
  end

  // driver tasks; each starts and ends 1ns after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic aw_phase(input logic [7:0] a);
    int t = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && t < BOUND) begin @(negedge clk); t++; end
    if (!s_axi_awready) timeout("aw_handshake");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && t < BOUND) begin @(negedge clk); t++; end
    if (!s_axi_wready) timeout("w_handshake");
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [7:0] a);
    int t = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && t < BOUND) begin @(negedge clk); t++; end
    if (!s_axi_arready) timeout("ar_handshake");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    bresp_q.push_back(2'b00);
    aw_phase(a);
    w_phase(d, s);
    @(negedge clk);
    while (!s_axi_bvalid && t < BOUND) begin @(negedge clk); t++; end
    if (!s_axi_bvalid) timeout("b_handshake");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] e);
    int t = 0;
    exp_q.push_back(e);
    addr_q.push_back(a);
    ar_phase(a);
    @(negedge clk);
    while (!s_axi_rvalid && t < BOUND) begin @(negedge clk); t++; end
    if (!s_axi_rvalid) timeout("r_handshake");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, {31'd0, s_axi_awready}, 32'd1);
    check({tag, "_arready"}, {31'd0, s_axi_arready}, 32'd1);
    check({tag, "_wready"},  {31'd0, s_axi_wready},  32'd0);
    check({tag, "_bvalid"},  {31'd0, s_axi_bvalid},  32'd0);
    check({tag, "_rvalid"},  {31'd0, s_axi_rvalid},  32'd0);
    check({tag, "_ap_start"}, {31'd0, ap_start},     32'd0);
    check({tag, "_ap_reset"}, {31'd0, ap_reset},     32'd0);
    check({tag, "_dcr_valid"}, {31'd0, dcr_wr_valid}, 32'd0);
    check({tag, "_interrupt"}, {31'd0, interrupt},   32'd0);
    check({tag, "_fsm_state"}, {29'd0, dbg_fsm_state}, 32'd0);
  endtask

  initial begin
    int s0;
    reset = 1'b1;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_rready = 1;
    ap_done = 0; ap_ready = 1; ap_idle = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // start with ap_ready tied high: one-cycle pulse, bit0 reads back 0
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'hF);
    idle(3);
    check("start_pulse_cycles", start_cnt - s0, 32'd1);
    axi_read(8'h00, 32'h08);

    // start write without lane 0 strobe is ignored
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'h2);
    idle(3);
    check("start_no_strobe", start_cnt - s0, 32'd0);

    // start held until ap_ready
    ap_ready = 0;
    axi_write(8'h00, 32'h1, 4'hF);
    axi_read(8'h00, 32'h01);
    ap_ready = 1;
    idle(3);
    axi_read(8'h00, 32'h08);

    // auto_restart keeps start set through ap_ready
    axi_write(8'h00, 32'h81, 4'hF);
    axi_read(8'h00, 32'h89);
    axi_write(8'h00, 32'h00, 4'hF);
    idle(2);
    axi_read(8'h00, 32'h08);

    // DCR address register and DCR writes with strobes
    s0 = dcr_cnt;
    axi_write(8'h18, 32'h005, 4'hF);
    axi_read(8'h18, 32'h005);
    dcr_q.push_back({12'h005, 32'hDEADBEEF});
    axi_write(8'h1C, 32'hDEADBEEF, 4'hF);
    dcr_q.push_back({12'h005, 32'h00FE000D});
    axi_write(8'h1C, 32'hCAFEF00D, 4'h5);
    axi_write(8'h18, 32'hFFFFFFFF, 4'hF);
    axi_read(8'h18, 32'h00000FFF);
    axi_write(8'h18, 32'hFFFFF123, 4'h1);
    axi_read(8'h18, 32'h00000F23);
    dcr_q.push_back({12'hF23, 32'h12345678});
    axi_write(8'h1C, 32'h12345678, 4'hF);
    axi_read(8'h1C, 32'h0);
    idle(2);
    check("dcr_pulse_count", dcr_cnt - s0, 32'd3);

    // done is sticky, read-clear, and a live done level wins over the clear
    ap_ready = 0; ap_idle = 1; ap_done = 1;
    idle(2);
    axi_read(8'h00, 32'h06);
    ap_done = 0;
    idle(2);
    axi_read(8'h00, 32'h06);
    axi_read(8'h00, 32'h04);

    // ap_reset pulse also clears a pending start
    s0 = rst_cnt;
    axi_write(8'h00, 32'h01, 4'hF);
    axi_write(8'h00, 32'h10, 4'hF);
    idle(3);
    check("ap_reset_pulse_cycles", rst_cnt - s0, 32'd1);
    @(negedge clk);
    check("start_cleared_by_reset", {31'd0, ap_start}, 32'd0);
    idle(1);
    axi_read(8'h00, 32'h04);

    // DEV_CAPS and unmapped offsets
    axi_read(8'h10, 32'h55667788);
    axi_read(8'h14, 32'h11223344);
    axi_read(8'h20, 32'h0);
    axi_write(8'h24, 32'hFFFFFFFF, 4'hF);
    axi_read(8'h00, 32'h04);

`ifdef VX_AFU_CTRL_IRQ_EN
    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h1, 4'hF);
    axi_read(8'h04, 32'h1);
    axi_read(8'h08, 32'h1);
    axi_read(8'h0C, 32'h0);
    ap_done = 1;
    idle(3);
    @(negedge clk);
    check("irq_on_done_edge", {31'd0, interrupt}, 32'd1);
    idle(1);
    axi_read(8'h0C, 32'h1);
    axi_write(8'h0C, 32'h1, 4'hF);
    idle(2);
    @(negedge clk);
    check("irq_cleared_by_toggle", {31'd0, interrupt}, 32'd0);
    idle(1);
    axi_read(8'h0C, 32'h0);
    axi_write(8'h0C, 32'h2, 4'hF);
    idle(2);
    @(negedge clk);
    check("irq_set_by_toggle", {31'd0, interrupt}, 32'd1);
    idle(1);
    axi_read(8'h0C, 32'h2);
    axi_write(8'h0C, 32'h2, 4'hF);
    idle(2);
    @(negedge clk);
    check("irq_toggle_back", {31'd0, interrupt}, 32'd0);
    idle(1);
`else
    axi_write(8'h04, 32'h1, 4'hF);
    axi_write(8'h08, 32'h3, 4'hF);
    axi_read(8'h04, 32'h0);
    axi_read(8'h08, 32'h0);
    ap_done = 1;
    idle(3);
    @(negedge clk);
    check("irq_tied_low", {31'd0, interrupt}, 32'd0);
    idle(1);
    axi_read(8'h0C, 32'h0);
`endif
    ap_done = 0;
    idle(2);

    // back-pressure: no new address accepted while a response is pending
    s_axi_bready = 0; s_axi_rready = 0;
    bresp_q.push_back(2'b00);
    aw_phase(8'h24);
    w_phase(32'h0, 4'hF);
    exp_q.push_back(32'h55667788);
    addr_q.push_back(8'h10);
    ar_phase(8'h10);
    s_axi_awaddr = 8'h24; s_axi_awvalid = 1;
    s_axi_araddr = 8'h14; s_axi_arvalid = 1;
    repeat (2) begin
      @(negedge clk);
      check("bp_awready", {31'd0, s_axi_awready}, 32'd0);
      check("bp_arready", {31'd0, s_axi_arready}, 32'd0);
      check("bp_bvalid_held", {31'd0, s_axi_bvalid}, 32'd1);
      check("bp_rvalid_held", {31'd0, s_axi_rvalid}, 32'd1);
    end
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_awready_back", {31'd0, s_axi_awready}, 32'd1);
    check("bp_arready_back", {31'd0, s_axi_arready}, 32'd1);
    idle(1);

    // reset in the middle of a write and a read aborts both
    s_axi_bready = 0; s_axi_rready = 0;
    aw_phase(8'h18);
    ar_phase(8'h10);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    s_axi_bready = 1; s_axi_rready = 1;
    idle(2);
    axi_read(8'h18, 32'h0);
    axi_read(8'h00, 32'h04);

    idle(3);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("bresp_q_empty", bresp_q.size(), 32'd0);
    check("dcr_q_empty", dcr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
